alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-driven controller for the 16x4 register-file + 2-bit-opcode ALU datapath (5-bit result).
//  Buffers LOAD/ALU commands in a FIFO and sequences each one onto the datapath's
//  addr/data/we/addrop1/addrop2/opcode/sel pins. Optionally writes the ALU result back and
//  returns each result on a valid/ready response port. Sits between the command source and the datapath.
// PARAMETERS
//  FIFO_DEPTH  4  command FIFO entries (power of 2, >=2)
//  DP_LAT      1  cycles from operand drive to a valid dp_out (>=1)
// PORTS
//  clock        in   1  single clock; all logic on rising edge
//  reset_n      in   1  reset, synchronous, active-low
//  cmd_valid    in   1  command offered
//  cmd_ready    out  1  command accepted on clock edge with cmd_valid&cmd_ready
//  cmd_kind     in   1  0=ALU, 1=LOAD
//  cmd_op       in   2  ALU opcode, passed to dp_opcode unchanged
//  cmd_src1     in   4  operand-1 register address
//  cmd_src2     in   4  operand-2 register address
//  cmd_dst      in   4  destination register (LOAD, or ALU with cmd_wb=1)
//  cmd_imm      in   4  LOAD immediate
//  cmd_wb       in   1  ALU: write result[3:0] to cmd_dst
//  rsp_valid    out  1  response available
//  rsp_ready    in   1  response consumed on clock edge with rsp_valid&rsp_ready
//  rsp_result   out  5  ALU: captured dp_out; LOAD: {1'b0,imm}
//  dp_addr      out  4  datapath write address
//  dp_data      out  4  datapath write data
//  dp_we        out  1  datapath write enable
//  dp_addrop1   out  4  datapath operand-1 address
//  dp_addrop2   out  4  datapath operand-2 address
//  dp_opcode    out  2  datapath ALU opcode
//  dp_sel       out  1  datapath output select, 1=ALU result
//  dp_out       in   5  datapath output
//  busy         out  1  FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): FIFO flushed; FSM->IDLE. All outputs 0, including cmd_ready.
//   cmd_ready=1 from the first edge with reset_n=1. Reset mid-command aborts it: no write, no response.
//  cmd_ready = !fifo_full, taken from the registered count (no same-cycle pass-through).
//   A push while full is ignored. Push and pop in the same cycle is legal; count unchanged.
//  FSM states: IDLE, ISSUE, WRITE, RESP.
//   IDLE:  FIFO non-empty -> pop into command register.
//          ALU -> ISSUE with counter=DP_LAT. LOAD -> WRITE.
//   ISSUE: drive dp_addrop1/2=src1/2, dp_opcode=op, dp_sel=1 and count down.
//          At the last cycle's edge, capture dp_out into result_q.
//          Then cmd_wb ? WRITE : RESP.
//   WRITE: exactly 1 cycle with dp_we=1, dp_addr=dst, dp_data = LOAD ? imm : result_q[3:0]
//          (carry bit dropped). Then -> RESP.
//   RESP:  rsp_valid=1 with rsp_result stable until rsp_ready. Handshake -> IDLE.
//          The FIFO keeps accepting while stalled here.
//  Latency, acceptance edge to rsp_valid high (DP_LAT=1): ALU no-wb 2, ALU wb 3, LOAD 2 cycles.
//   Add DP_LAT-1 for ALU commands.
//  One command in flight; strict FIFO order. A write completes before the next issue, so no RAW hazard.
//   dst==src is legal.
//  Outside ISSUE: dp_sel=0 and operand/opcode outputs hold 0. dp_we=1 only in WRITE.
//  FIFO pointers wrap modulo FIFO_DEPTH; a full/empty ambiguity is resolved by a count register.
// STRUCTURE
//  alu_seq_defs.vh: state encodings, CMD_KIND_ALU/LOAD, command word width and field offsets.
//  Sub-module cmd_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty/count.
//   Holds the packed command word. FSM and datapath drive logic stay in this module.
// TESTING (bench uses a behavioural regfile+ALU model, opcode 0 = add, DP_LAT cycles out latency)
//  1 Reset: reset_n=0 for 2 cycles with cmd_valid=1 -> cmd_ready=0, dp_we=0, rsp_valid=0.
//    After release -> cmd_ready=1, busy=0.
//  2 LOAD r0=10, LOAD r4=14, then ALU op0 src 0,4 dst 7 wb=1.
//    -> rsp_result 10, 14, 24 in order; r7 holds 8; dp_we pulsed exactly 3 single cycles.
//  3 Latency, DP_LAT=1: ALU wb=0 -> rsp_valid exactly 2 cycles after accept.
//    Same check at DP_LAT=3 -> 4 cycles; dp_sel=1 for exactly 3 cycles.
//  4 Backpressure: rsp_ready=0, offer 6 commands -> 5 accepted (4 FIFO + 1 in RESP), then cmd_ready=0.
//    Raise rsp_ready -> all 5 responses in order, none lost or duplicated.
//  5 Reset asserted during WRITE of an ALU wb command -> dp_we=0 after that edge.
//    Target register unchanged, FIFO empty, no rsp_valid.
//  6 Stream 20 random commands with rsp_ready toggling randomly and simultaneous push/pop at full
//    -> responses match model order and values; pointers wrap cleanly.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: FSM states, command kinds and the packed command word.
package alu_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic CMD_KIND_ALU  = 1'b0;
  localparam logic CMD_KIND_LOAD = 1'b1;

  typedef struct packed {
    logic       kind;
    logic [1:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dst;
    logic [3:0] imm;
    logic       wb;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO; an occupancy count register disambiguates full from empty.
module cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define the contents.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences buffered LOAD/ALU commands onto the regfile+ALU datapath pins and returns one response each.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DP_LAT     = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_kind,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_src1,
  input  logic [3:0] cmd_src2,
  input  logic [3:0] cmd_dst,
  input  logic [3:0] cmd_imm,
  input  logic       cmd_wb,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_result,
  output logic [3:0] dp_addr,
  output logic [3:0] dp_data,
  output logic       dp_we,
  output logic [3:0] dp_addrop1,
  output logic [3:0] dp_addrop2,
  output logic [1:0] dp_opcode,
  output logic       dp_sel,
  input  logic [4:0] dp_out,
  output logic       busy
);

  localparam int CW = $clog2(DP_LAT + 1);

  state_t                      state;
  logic                        started;
  logic [CW-1:0]               lat_cnt;
  logic [4:0]                  result_q;
  logic                        wb_q;
  logic [3:0]                  dst_q;
  cmd_t                        cmd_in;
  cmd_t                        head;
  logic [CMD_W-1:0]            fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        push;
  logic                        pop;

  assign cmd_in = '{kind: cmd_kind, op: cmd_op, src1: cmd_src1, src2: cmd_src2,
                    dst: cmd_dst, imm: cmd_imm, wb: cmd_wb};
  assign head   = cmd_t'(fifo_rdata);

  // started keeps cmd_ready low through the reset edge without a combinational path from reset_n.
  assign cmd_ready = started && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (cmd_in),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      started    <= 1'b0;
      lat_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      dp_addr    <= '0;
      dp_data    <= '0;
      dp_we      <= 1'b0;
      dp_addrop1 <= '0;
      dp_addrop2 <= '0;
      dp_opcode  <= '0;
      dp_sel     <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            wb_q  <= head.wb;
            dst_q <= head.dst;
            if (head.kind == CMD_KIND_LOAD) begin
              state    <= ST_WRITE;
              dp_we    <= 1'b1;
              dp_addr  <= head.dst;
              dp_data  <= head.imm;
              result_q <= {1'b0, head.imm};
            end else begin
              state      <= ST_ISSUE;
              lat_cnt    <= CW'(DP_LAT);
              dp_sel     <= 1'b1;
              dp_addrop1 <= head.src1;
              dp_addrop2 <= head.src2;
              dp_opcode  <= head.op;
            end
          end
        end
        ST_ISSUE: begin
          if (lat_cnt == CW'(1)) begin
            result_q   <= dp_out;
            dp_sel     <= 1'b0;
            dp_addrop1 <= '0;
            dp_addrop2 <= '0;
            dp_opcode  <= '0;
            if (wb_q) begin
              state   <= ST_WRITE;
              dp_we   <= 1'b1;
              dp_addr <= dst_q;
              dp_data <= dp_out[3:0];
            end else begin
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= dp_out;
            end
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          dp_we      <= 1'b0;
          dp_addr    <= '0;
          dp_data    <= '0;
          rsp_valid  <= 1'b1;
          rsp_result <= result_q;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
